// File: rtl/conv3x3_edge_pipe.sv
// conv3x3_edge_pipe: 4-stage 3x3 gradient engine with loadable X/Y kernels,
// four output modes and valid/ready backpressure.
module conv3x3_edge_pipe #(
  parameter int PIX_W = 8,
  parameter int COEF_W = 4,
  parameter int OUT_W = 8,
  localparam int SUM_W = PIX_W + COEF_W + 5
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [9*PIX_W-1:0]  i_pixel_data,
  input  logic                i_pixel_data_valid,
  output logic                o_pixel_ready,
  input  logic [1:0]          i_mode,
  input  logic [2*SUM_W:0]    i_threshold,
  input  logic                i_cfg_wr,
  input  logic [4:0]          i_cfg_addr,
  input  logic [COEF_W-1:0]   i_cfg_data,
  output logic                o_cfg_err,
  output logic                o_busy,
  output logic [OUT_W-1:0]    o_convolved_data,
  output logic                o_convolved_data_valid,
  input  logic                i_out_ready
);

  localparam int PRD_W = PIX_W + COEF_W + 1;
  localparam int MAG_W = 2 * SUM_W + 1;
  localparam logic [MAG_W-1:0] OUT_MAX =
    MAG_W'((1 << OUT_W) - 1);

  logic signed [COEF_W-1:0] kx [9];
  logic signed [COEF_W-1:0] ky [9];

  logic                    s1_vld;
  logic [1:0]              s1_mode;
  logic signed [PRD_W-1:0] s1_px [9];
  logic signed [PRD_W-1:0] s1_py [9];

  logic                    s2_vld;
  logic [1:0]              s2_mode;
  logic signed [SUM_W-1:0] s2_gx;
  logic signed [SUM_W-1:0] s2_gy;

  logic                    s3_vld;
  logic [1:0]              s3_mode;
  logic [MAG_W-1:0]        s3_mag;

  logic                    stall;
  logic                    adv;
  logic                    cfg_ok;
  logic signed [SUM_W-1:0] gx_c;
  logic signed [SUM_W-1:0] gy_c;
  logic [SUM_W-1:0]        ax;
  logic [SUM_W-1:0]        ay;
  logic [MAG_W-1:0]        mag_c;
  logic [OUT_W-1:0]        res_c;

  function automatic logic signed [COEF_W-1:0]
    sobel_x(input int k);
    int v;
    case (k)
      0, 6:    v = 1;
      2, 8:    v = -1;
      3:       v = 2;
      5:       v = -2;
      default: v = 0;
    endcase
    return COEF_W'(v);
  endfunction

  function automatic logic signed [COEF_W-1:0]
    sobel_y(input int k);
    int v;
    case (k)
      0, 2:    v = 1;
      1:       v = 2;
      6, 8:    v = -1;
      7:       v = -2;
      default: v = 0;
    endcase
    return COEF_W'(v);
  endfunction

  // pixel is zero-extended so it stays non-negative as a signed operand
  function automatic logic signed [PRD_W-1:0] mul(
    input logic signed [COEF_W-1:0] c,
    input logic [PIX_W-1:0]         p
  );
    logic signed [PRD_W-1:0] cs;
    logic signed [PRD_W-1:0] ps;
    cs = PRD_W'(c);
    ps = PRD_W'({1'b0, p});
    return cs * ps;
  endfunction

  assign stall = o_convolved_data_valid & ~i_out_ready;
  assign adv = ~stall;
  assign o_pixel_ready = adv;
  assign o_busy = s1_vld | s2_vld | s3_vld
                | o_convolved_data_valid;
  assign cfg_ok = ~o_busy & ~i_pixel_data_valid
                & (i_cfg_addr <= 5'd17);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < 9; k++) begin
        kx[k] <= sobel_x(k);
        ky[k] <= sobel_y(k);
      end
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= i_cfg_wr & ~cfg_ok;
      if (i_cfg_wr && cfg_ok) begin
        for (int k = 0; k < 9; k++) begin
          if (i_cfg_addr == 5'(k))
            kx[k] <= i_cfg_data;
          if (i_cfg_addr == 5'(k + 9))
            ky[k] <= i_cfg_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_vld <= 1'b0;
      s1_mode <= '0;
      for (int k = 0; k < 9; k++) begin
        s1_px[k] <= '0;
        s1_py[k] <= '0;
      end
    end else if (adv) begin
      s1_vld <= i_pixel_data_valid;
      s1_mode <= i_mode;
      for (int k = 0; k < 9; k++) begin
        s1_px[k] <= mul(kx[k],
          i_pixel_data[k*PIX_W +: PIX_W]);
        s1_py[k] <= mul(ky[k],
          i_pixel_data[k*PIX_W +: PIX_W]);
      end
    end
  end

  always_comb begin
    gx_c = '0;
    gy_c = '0;
    for (int k = 0; k < 9; k++) begin
      gx_c = gx_c + SUM_W'(s1_px[k]);
      gy_c = gy_c + SUM_W'(s1_py[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_vld <= 1'b0;
      s2_mode <= '0;
      s2_gx <= '0;
      s2_gy <= '0;
    end else if (adv) begin
      s2_vld <= s1_vld;
      s2_mode <= s1_mode;
      s2_gx <= gx_c;
      s2_gy <= gy_c;
    end
  end

  always_comb begin
    ax = s2_gx[SUM_W-1] ? -s2_gx : s2_gx;
    ay = s2_gy[SUM_W-1] ? -s2_gy : s2_gy;
    mag_c = '0;
    unique case (s2_mode)
      2'd0: mag_c = MAG_W'(ax) * MAG_W'(ax)
                  + MAG_W'(ay) * MAG_W'(ay);
      2'd1: mag_c = MAG_W'(ax) + MAG_W'(ay);
      2'd2: mag_c = MAG_W'(ax);
      2'd3: mag_c = MAG_W'(ay);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s3_vld <= 1'b0;
      s3_mode <= '0;
      s3_mag <= '0;
    end else if (adv) begin
      s3_vld <= s2_vld;
      s3_mode <= s2_mode;
      s3_mag <= mag_c;
    end
  end

  always_comb begin
    res_c = '0;
    if (s3_mode == 2'd0)
      res_c = (s3_mag > i_threshold) ? '1 : '0;
    else if (s3_mag > OUT_MAX)
      res_c = '1;
    else
      res_c = s3_mag[OUT_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_convolved_data_valid <= 1'b0;
      o_convolved_data <= '0;
    end else if (adv) begin
      o_convolved_data_valid <= s3_vld;
      o_convolved_data <= res_c;
    end
  end

endmodule

// File: tb/tb_conv3x3_edge_pipe.sv
// tb_conv3x3_edge_pipe: directed windows with a scoreboard queue
// drained by an independent output monitor.
module tb_conv3x3_edge_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] pix;
  logic        pvld;
  logic        rdy;
  logic [1:0]  mode;
  logic [34:0] thr;
  logic        cfg_wr;
  logic [4:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        cfg_err;
  logic        busy;
  logic [7:0]  odata;
  logic        ovld;
  logic        out_ready;

  int total = 0;
  int bad = 0;
  int n_out = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  conv3x3_edge_pipe dut (
    .i_clk                  (clk),
    .i_rstn                 (rst_n),
    .i_pixel_data           (pix),
    .i_pixel_data_valid     (pvld),
    .o_pixel_ready          (rdy),
    .i_mode                 (mode),
    .i_threshold            (thr),
    .i_cfg_wr               (cfg_wr),
    .i_cfg_addr             (cfg_addr),
    .i_cfg_data             (cfg_data),
    .o_cfg_err              (cfg_err),
    .o_busy                 (busy),
    .o_convolved_data       (odata),
    .o_convolved_data_valid (ovld),
    .i_out_ready            (out_ready)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [71:0] flat(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] lcol(input logic [7:0] v);
    logic [71:0] w;
    w = '0;
    w[0+:8] = v;
    w[24+:8] = v;
    w[48+:8] = v;
    return w;
  endfunction

  // output monitor: a beat transfers when valid and ready at the edge
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ovld && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got=%0h", odata);
        end else begin
          e = exp_q.pop_front();
          chk("out", odata, e);
        end
      end
    end
  end

  task automatic send(input logic [71:0] w,
                      input logic [1:0] m,
                      input logic [7:0] e);
    int n;
    n = 0;
    pix = w;
    mode = m;
    pvld = 1'b1;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait", n < 50, 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pvld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < 100, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] a,
                     input logic [3:0] d);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int out0;
    rst_n = 1'b0;
    pix = '0;
    pvld = 1'b0;
    mode = 2'd0;
    thr = '0;
    cfg_wr = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ovld, 0);
    chk("rst_data", odata, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rdy, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    thr = 35'd4000;
    send(flat(8'd100), 2'd0, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("lat%0d", i), ovld, i == 4);
    end
    drain();

    thr = 35'd1600;
    send(lcol(8'd10), 2'd0, 8'h00);
    drain();
    thr = 35'd1599;
    send(lcol(8'd10), 2'd0, 8'hFF);
    drain();

    send(lcol(8'd255), 2'd0, 8'hFF);
    send(lcol(8'd255), 2'd1, 8'hFF);
    send(lcol(8'd255), 2'd2, 8'hFF);
    send(lcol(8'd255), 2'd3, 8'h00);
    drain();

    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(lcol(8'(i + 1)), 2'd2, 8'(4 * (i + 1)));
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rdy_pre", rdy, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_rdy", rdy, 0);
          chk("stall_vld", ovld, 1);
          chk("stall_data", odata, 8'd12);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rdy_post", rdy, 1);
      end
    join
    drain();
    chk("stream_count", n_out - out0, 10);

    cfg(5'd4, 4'd3);
    @(negedge clk);
    chk("cfg_ok_err", cfg_err, 0);
    @(posedge clk);
    #1;
    send(flat(8'd5), 2'd2, 8'd15);
    cfg(5'd4, 4'd7);
    @(negedge clk);
    chk("cfg_busy_err", cfg_err, 1);
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 0);
    drain();
    send(flat(8'd5), 2'd2, 8'd15);
    drain();

    pix = flat(8'd5);
    mode = 2'd2;
    pvld = 1'b1;
    cfg_wr = 1'b1;
    cfg_addr = 5'd4;
    cfg_data = 4'd1;
    @(negedge clk);
    chk("simul_rdy", rdy, 1);
    exp_q.push_back(8'd15);
    @(posedge clk);
    #1;
    pvld = 1'b0;
    cfg_wr = 1'b0;
    @(negedge clk);
    chk("simul_err", cfg_err, 1);
    drain();
    send(flat(8'd5), 2'd2, 8'd15);
    drain();

    cfg(5'd20, 4'd1);
    @(negedge clk);
    chk("cfg_addr_err", cfg_err, 1);
    @(posedge clk);
    #1;

    send(flat(8'd5), 2'd2, 8'd15);
    send(flat(8'd5), 2'd2, 8'd15);
    send(flat(8'd5), 2'd2, 8'd15);
    @(posedge clk);
    #2;
    chk("pre_rst_vld", ovld, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_vld", ovld, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", ovld, 0);
    end
    @(posedge clk);
    #1;
    send(flat(8'd5), 2'd2, 8'd0);
    send(lcol(8'd10), 2'd2, 8'd40);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
